// File: rtl/wb_reg_pkg.sv
// Shared definitions for the Wishbone register responder: bus widths,
// FSM state encoding and the word indices of the register map.
package wb_reg_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int SEL_W  = DATA_W / 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  localparam logic [2:0] REG_ID       = 3'd0;
  localparam logic [2:0] REG_SCRATCH0 = 3'd1;
  localparam logic [2:0] REG_SCRATCH1 = 3'd2;
  localparam logic [2:0] REG_CTRL     = 3'd3;
  localparam logic [2:0] REG_STATUS   = 3'd4;
  localparam logic [2:0] REG_WR_COUNT = 3'd5;

endpackage

// File: rtl/wb_reg_responder_if.sv
// Wishbone classic-cycle bus bundle between a master agent and the
// register responder; signal names follow the slave's point of view.
interface wb_reg_responder_if;
  import wb_reg_pkg::*;

  logic              wb_cyc_i;
  logic              wb_stb_i;
  logic              wb_we_i;
  logic [ADDR_W-1:0] wb_addr_i;
  logic [SEL_W-1:0]  wb_sel_i;
  logic [DATA_W-1:0] wb_dat_i;
  logic [DATA_W-1:0] wb_dat_o;
  logic              wb_ack_o;

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_addr_i, wb_sel_i, wb_dat_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_addr_i, wb_sel_i, wb_dat_i,
    output wb_dat_o, wb_ack_o
  );

endinterface

// File: rtl/wb_byte_lane_merge.sv
// Combinational write merge: each byte lane takes the new value when its
// select bit is set and keeps the old register value otherwise.
module wb_byte_lane_merge
  import wb_reg_pkg::*;
(
  input  logic [DATA_W-1:0] i_old,
  input  logic [DATA_W-1:0] i_new,
  input  logic [SEL_W-1:0]  i_sel,
  output logic [DATA_W-1:0] o_merged
);

  always_comb begin
    o_merged = i_old;
    for (int n = 0; n < SEL_W; n++) begin
      if (i_sel[n]) begin
        o_merged[8*n +: 8] = i_new[8*n +: 8];
      end
    end
  end

endmodule

// File: rtl/wb_reg_responder.sv
// Wishbone classic-cycle register responder with programmable wait states,
// scratch/control registers, sticky W1C event status and a write counter.
module wb_reg_responder
  import wb_reg_pkg::*;
#(
  parameter int               WAIT_STATES = 1,
  parameter logic [DATA_W-1:0] ID_VALUE   = 32'h5541_5254
)
(
  input  logic                wb_clk_i,
  input  logic                wb_rst_ni,
  wb_reg_responder_if.slave   wb,
  input  logic [7:0]          event_i,
  output logic                int_o
);

  localparam bit         NO_WAIT   = (WAIT_STATES == 0);
  localparam logic [2:0] WAIT_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  state_t            r_state;
  logic [2:0]        r_waitCnt;
  logic [2:0]        r_addr;
  logic              r_we;
  logic [SEL_W-1:0]  r_sel;
  logic [DATA_W-1:0] r_dat;
  logic              r_ack;
  logic [DATA_W-1:0] r_datO;

  logic [DATA_W-1:0] r_scratch0;
  logic [DATA_W-1:0] r_scratch1;
  logic              r_irqEn;
  logic [7:0]        r_status;
  logic [15:0]       r_wrCount;
  logic              r_int;

  logic              w_req;
  logic              w_commit;
  logic              w_wrEn;
  logic [2:0]        w_curAddr;
  logic              w_curWe;
  logic [SEL_W-1:0]  w_curSel;
  logic [DATA_W-1:0] w_curDat;
  logic [DATA_W-1:0] w_readData;
  logic [DATA_W-1:0] w_scratch0Merged;
  logic [DATA_W-1:0] w_scratch1Merged;
  logic [DATA_W-1:0] w_ctrlMerged;
  logic [7:0]        w_statusClr;
  logic              w_unusedBits;

  assign w_req = wb.wb_cyc_i & wb.wb_stb_i;

  // With no wait states the commit happens on the sample edge itself, so the
  // live bus fields are used in IDLE and the captured copies afterwards.
  assign w_curAddr = (r_state == ST_IDLE) ? wb.wb_addr_i[4:2] : r_addr;
  assign w_curWe   = (r_state == ST_IDLE) ? wb.wb_we_i        : r_we;
  assign w_curSel  = (r_state == ST_IDLE) ? wb.wb_sel_i       : r_sel;
  assign w_curDat  = (r_state == ST_IDLE) ? wb.wb_dat_i       : r_dat;

  assign w_commit = w_req & (((r_state == ST_IDLE) & NO_WAIT) |
                             ((r_state == ST_WAIT) & (r_waitCnt == 3'd0)));
  assign w_wrEn   = w_commit & w_curWe;

  assign w_unusedBits = ^{wb.wb_addr_i[1:0], w_ctrlMerged[DATA_W-1:1]};

  always_comb begin
    w_readData = '0;
    case (w_curAddr)
      REG_ID:       w_readData = ID_VALUE;
      REG_SCRATCH0: w_readData = r_scratch0;
      REG_SCRATCH1: w_readData = r_scratch1;
      REG_CTRL:     w_readData = {{(DATA_W-1){1'b0}}, r_irqEn};
      REG_STATUS:   w_readData = {{(DATA_W-8){1'b0}}, r_status};
      REG_WR_COUNT: w_readData = {{(DATA_W-16){1'b0}}, r_wrCount};
      default:      w_readData = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_state   <= ST_IDLE;
      r_waitCnt <= 3'd0;
      r_addr    <= 3'd0;
      r_we      <= 1'b0;
      r_sel     <= '0;
      r_dat     <= '0;
      r_ack     <= 1'b0;
      r_datO    <= '0;
    end else begin
      r_ack  <= w_commit;
      r_datO <= (w_commit && !w_curWe) ? w_readData : '0;
      case (r_state)
        ST_IDLE: begin
          if (w_req) begin
            r_addr <= wb.wb_addr_i[4:2];
            r_we   <= wb.wb_we_i;
            r_sel  <= wb.wb_sel_i;
            r_dat  <= wb.wb_dat_i;
            if (NO_WAIT) begin
              r_state <= ST_ACK;
            end else begin
              r_state   <= ST_WAIT;
              r_waitCnt <= WAIT_LOAD;
            end
          end
        end
        ST_WAIT: begin
          // Master giving up mid-wait aborts silently: no ack, no commit.
          if (!w_req) begin
            r_state <= ST_IDLE;
          end else if (r_waitCnt == 3'd0) begin
            r_state <= ST_ACK;
          end else begin
            r_waitCnt <= r_waitCnt - 3'd1;
          end
        end
        ST_ACK:  r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  wb_byte_lane_merge u_mergeScratch0 (
    .i_old    (r_scratch0),
    .i_new    (w_curDat),
    .i_sel    (w_curSel),
    .o_merged (w_scratch0Merged)
  );

  wb_byte_lane_merge u_mergeScratch1 (
    .i_old    (r_scratch1),
    .i_new    (w_curDat),
    .i_sel    (w_curSel),
    .o_merged (w_scratch1Merged)
  );

  wb_byte_lane_merge u_mergeCtrl (
    .i_old    ({{(DATA_W-1){1'b0}}, r_irqEn}),
    .i_new    (w_curDat),
    .i_sel    (w_curSel),
    .o_merged (w_ctrlMerged)
  );

  assign w_statusClr = (w_wrEn && (w_curAddr == REG_STATUS) && w_curSel[0]) ?
                       w_curDat[7:0] : 8'h00;

  // Event set is ORed in after the clear so a coincident event wins.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_scratch0 <= '0;
      r_scratch1 <= '0;
      r_irqEn    <= 1'b0;
      r_status   <= 8'h00;
      r_wrCount  <= 16'h0000;
      r_int      <= 1'b0;
    end else begin
      if (w_wrEn && (w_curAddr == REG_SCRATCH0)) r_scratch0 <= w_scratch0Merged;
      if (w_wrEn && (w_curAddr == REG_SCRATCH1)) r_scratch1 <= w_scratch1Merged;
      if (w_wrEn && (w_curAddr == REG_CTRL))     r_irqEn    <= w_ctrlMerged[0];
      if (w_wrEn)                                r_wrCount  <= r_wrCount + 16'd1;
      r_status <= (r_status & ~w_statusClr) | event_i;
      r_int    <= r_irqEn & (|r_status);
    end
  end

  assign wb.wb_ack_o = r_ack;
  assign wb.wb_dat_o = r_datO;
  assign int_o       = r_int;

endmodule

// File: tb/tb_wb_reg_responder.sv
// Directed self-checking bench for wb_reg_responder: one instance with one
// wait state for most scenarios and one with three for abort/hold cases.
module tb_wb_reg_responder;

  localparam logic [31:0] ID_EXP = 32'h5541_5254;

  logic       clk;
  logic       rst_n;
  logic [7:0] eventIn;
  logic       intOut;
  logic       intOut3;
  int         nChecks;
  int         nFails;

  wb_reg_responder_if bus ();
  wb_reg_responder_if bus3 ();

  wb_reg_responder #(.WAIT_STATES(1), .ID_VALUE(ID_EXP)) dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .wb        (bus),
    .event_i   (eventIn),
    .int_o     (intOut)
  );

  wb_reg_responder #(.WAIT_STATES(3), .ID_VALUE(ID_EXP)) dut3 (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .wb        (bus3),
    .event_i   (8'h00),
    .int_o     (intOut3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic driveBus(input bit slow, input bit cyc, input bit stb, input bit we,
                          input logic [4:0] addr, input logic [3:0] sel, input logic [31:0] dat);
    if (slow) begin
      bus3.wb_cyc_i = cyc; bus3.wb_stb_i = stb; bus3.wb_we_i = we;
      bus3.wb_addr_i = addr; bus3.wb_sel_i = sel; bus3.wb_dat_i = dat;
    end else begin
      bus.wb_cyc_i = cyc; bus.wb_stb_i = stb; bus.wb_we_i = we;
      bus.wb_addr_i = addr; bus.wb_sel_i = sel; bus.wb_dat_i = dat;
    end
  endtask

  // Runs one transfer; returns at the negedge where ack is first seen.
  task automatic doXfer(input bit slow, input bit we, input logic [4:0] addr,
                        input logic [3:0] sel, input logic [31:0] dat,
                        output logic [31:0] rdata, output int lat);
    logic ackNow;
    @(negedge clk);
    driveBus(slow, 1'b1, 1'b1, we, addr, sel, dat);
    lat   = -1;
    rdata = '0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      ackNow = slow ? bus3.wb_ack_o : bus.wb_ack_o;
      if (ackNow) begin
        lat   = i;
        rdata = slow ? bus3.wb_dat_o : bus.wb_dat_o;
        break;
      end
    end
    driveBus(slow, 1'b0, 1'b0, 1'b0, 5'd0, 4'h0, 32'h0);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    eventIn = 8'h00;
    driveBus(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 4'h0, 32'h0);
    driveBus(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 4'h0, 32'h0);
    repeat (3) @(negedge clk);
    nChecks++; if (bus.wb_ack_o !== 1'b0) begin nFails++; $display("[TB] FAIL reset_ack: got %b expected 0", bus.wb_ack_o); end
    nChecks++; if (bus.wb_dat_o !== 32'h0) begin nFails++; $display("[TB] FAIL reset_dat: got %h expected 0", bus.wb_dat_o); end
    nChecks++; if (intOut !== 1'b0) begin nFails++; $display("[TB] FAIL reset_int: got %b expected 0", intOut); end
    nChecks++; if (bus3.wb_ack_o !== 1'b0) begin nFails++; $display("[TB] FAIL reset_ack3: got %b expected 0", bus3.wb_ack_o); end
    rst_n = 1'b1;
  endtask

  task automatic test_read_all;
    logic [31:0] rd;
    logic [31:0] exp;
    int lat;
    for (int i = 0; i < 8; i++) begin
      doXfer(1'b0, 1'b0, 5'(i * 4), 4'hF, 32'h0, rd, lat);
      exp = (i == 0) ? ID_EXP : 32'h0;
      nChecks++; if (rd !== exp) begin nFails++; $display("[TB] FAIL read_word%0d: got %h expected %h", i, rd, exp); end
      nChecks++; if (lat != 2) begin nFails++; $display("[TB] FAIL read_lat%0d: got %0d expected 2", i, lat); end
      if (i == 0) begin
        @(negedge clk);
        nChecks++; if (bus.wb_ack_o !== 1'b0) begin nFails++; $display("[TB] FAIL ack_single_cycle: got %b expected 0", bus.wb_ack_o); end
        nChecks++; if (bus.wb_dat_o !== 32'h0) begin nFails++; $display("[TB] FAIL dat_after_ack: got %h expected 0", bus.wb_dat_o); end
      end
    end
  endtask

  task automatic test_byte_lanes;
    logic [31:0] rd;
    int lat;
    doXfer(1'b0, 1'b1, 5'd4, 4'b0101, 32'hDEAD_BEEF, rd, lat);
    nChecks++; if (lat != 2) begin nFails++; $display("[TB] FAIL write_lat: got %0d expected 2", lat); end
    doXfer(1'b0, 1'b0, 5'd4, 4'hF, 32'h0, rd, lat);
    nChecks++; if (rd !== 32'h00AD_00EF) begin nFails++; $display("[TB] FAIL scratch0_lanes: got %h expected 00ad00ef", rd); end
    doXfer(1'b0, 1'b0, 5'd20, 4'hF, 32'h0, rd, lat);
    nChecks++; if (rd !== 32'h1) begin nFails++; $display("[TB] FAIL wrcount_one: got %h expected 1", rd); end
    doXfer(1'b0, 1'b1, 5'd8, 4'b1010, 32'h1122_3344, rd, lat);
    doXfer(1'b0, 1'b0, 5'd8, 4'hF, 32'h0, rd, lat);
    nChecks++; if (rd !== 32'h1100_3300) begin nFails++; $display("[TB] FAIL scratch1_lanes: got %h expected 11003300", rd); end
    doXfer(1'b0, 1'b1, 5'd8, 4'b0000, 32'hFFFF_FFFF, rd, lat);
    doXfer(1'b0, 1'b0, 5'd8, 4'hF, 32'h0, rd, lat);
    nChecks++; if (rd !== 32'h1100_3300) begin nFails++; $display("[TB] FAIL scratch1_sel0: got %h expected 11003300", rd); end
    doXfer(1'b0, 1'b1, 5'd12, 4'hF, 32'hFFFF_FFFF, rd, lat);
    doXfer(1'b0, 1'b0, 5'd12, 4'hF, 32'h0, rd, lat);
    nChecks++; if (rd !== 32'h1) begin nFails++; $display("[TB] FAIL ctrl_mask: got %h expected 1", rd); end
    doXfer(1'b0, 1'b0, 5'd20, 4'hF, 32'h0, rd, lat);
    nChecks++; if (rd !== 32'h4) begin nFails++; $display("[TB] FAIL wrcount_four: got %h expected 4", rd); end
  endtask

  task automatic test_back_to_back;
    logic [8:0] pat;
    int badData;
    badData = 0;
    @(negedge clk);
    driveBus(1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 4'hF, 32'h0);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      pat[i] = bus.wb_ack_o;
      if (bus.wb_ack_o && bus.wb_dat_o !== ID_EXP) badData++;
    end
    driveBus(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 4'h0, 32'h0);
    nChecks++; if (pat !== 9'b010010010) begin nFails++; $display("[TB] FAIL b2b_ack_pattern: got %b expected 010010010", pat); end
    nChecks++; if (badData != 0) begin nFails++; $display("[TB] FAIL b2b_data: got %0d bad beats expected 0", badData); end
  endtask

  task automatic test_abort;
    logic [31:0] rd;
    int lat;
    int acks;
    acks = 0;
    @(negedge clk);
    driveBus(1'b1, 1'b1, 1'b1, 1'b1, 5'd8, 4'hF, 32'h1234_5678);
    @(negedge clk);
    bus3.wb_stb_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus3.wb_ack_o) acks++;
    end
    driveBus(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 4'h0, 32'h0);
    nChecks++; if (acks != 0) begin nFails++; $display("[TB] FAIL abort_ack: got %0d acks expected 0", acks); end
    doXfer(1'b1, 1'b0, 5'd8, 4'hF, 32'h0, rd, lat);
    nChecks++; if (rd !== 32'h0) begin nFails++; $display("[TB] FAIL abort_scratch1: got %h expected 0", rd); end
    nChecks++; if (lat != 4) begin nFails++; $display("[TB] FAIL slow_lat: got %0d expected 4", lat); end
    doXfer(1'b1, 1'b0, 5'd20, 4'hF, 32'h0, rd, lat);
    nChecks++; if (rd !== 32'h0) begin nFails++; $display("[TB] FAIL abort_wrcount: got %h expected 0", rd); end

    // Fields changed after the sample edge must not affect the write.
    acks = 0;
    @(negedge clk);
    driveBus(1'b1, 1'b1, 1'b1, 1'b1, 5'd8, 4'hF, 32'hABCD_1234);
    @(negedge clk);
    bus3.wb_addr_i = 5'd4; bus3.wb_dat_i = 32'h0; bus3.wb_sel_i = 4'h0; bus3.wb_we_i = 1'b0;
    for (int i = 0; i < 10 && acks == 0; i++) begin
      @(negedge clk);
      if (bus3.wb_ack_o) acks++;
    end
    driveBus(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 4'h0, 32'h0);
    nChecks++; if (acks != 1) begin nFails++; $display("[TB] FAIL hold_ack: got %0d expected 1", acks); end
    doXfer(1'b1, 1'b0, 5'd8, 4'hF, 32'h0, rd, lat);
    nChecks++; if (rd !== 32'hABCD_1234) begin nFails++; $display("[TB] FAIL hold_scratch1: got %h expected abcd1234", rd); end
    doXfer(1'b1, 1'b0, 5'd4, 4'hF, 32'h0, rd, lat);
    nChecks++; if (rd !== 32'h0) begin nFails++; $display("[TB] FAIL hold_scratch0: got %h expected 0", rd); end
  endtask

  task automatic test_irq;
    logic [31:0] rd;
    int lat;
    doXfer(1'b0, 1'b1, 5'd12, 4'h1, 32'h1, rd, lat);
    @(negedge clk);
    nChecks++; if (intOut !== 1'b0) begin nFails++; $display("[TB] FAIL irq_idle: got %b expected 0", intOut); end
    eventIn = 8'h04;
    @(negedge clk);
    eventIn = 8'h00;
    @(negedge clk);
    nChecks++; if (intOut !== 1'b1) begin nFails++; $display("[TB] FAIL irq_event: got %b expected 1", intOut); end

    // Clear and a fresh event land on the same commit edge.
    driveBus(1'b0, 1'b1, 1'b1, 1'b1, 5'd16, 4'h1, 32'h4);
    @(negedge clk);
    eventIn = 8'h04;
    @(negedge clk);
    eventIn = 8'h00;
    nChecks++; if (bus.wb_ack_o !== 1'b1) begin nFails++; $display("[TB] FAIL w1c_race_ack: got %b expected 1", bus.wb_ack_o); end
    driveBus(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 4'h0, 32'h0);
    repeat (2) @(negedge clk);
    nChecks++; if (intOut !== 1'b1) begin nFails++; $display("[TB] FAIL w1c_race_int: got %b expected 1", intOut); end
    doXfer(1'b0, 1'b0, 5'd16, 4'hF, 32'h0, rd, lat);
    nChecks++; if (rd !== 32'h4) begin nFails++; $display("[TB] FAIL w1c_race_status: got %h expected 4", rd); end

    doXfer(1'b0, 1'b1, 5'd16, 4'b1110, 32'hFF, rd, lat);
    repeat (2) @(negedge clk);
    nChecks++; if (intOut !== 1'b1) begin nFails++; $display("[TB] FAIL w1c_nosel_int: got %b expected 1", intOut); end

    doXfer(1'b0, 1'b1, 5'd16, 4'h1, 32'h4, rd, lat);
    nChecks++; if (intOut !== 1'b1) begin nFails++; $display("[TB] FAIL w1c_int_at_ack: got %b expected 1", intOut); end
    @(negedge clk);
    nChecks++; if (intOut !== 1'b0) begin nFails++; $display("[TB] FAIL w1c_int_drop: got %b expected 0", intOut); end
    doXfer(1'b0, 1'b0, 5'd16, 4'hF, 32'h0, rd, lat);
    nChecks++; if (rd !== 32'h0) begin nFails++; $display("[TB] FAIL w1c_status: got %h expected 0", rd); end
  endtask

  task automatic test_wrap;
    logic [31:0] rd;
    int lat;
    force dut.r_wrCount = 16'hFFFE;
    @(negedge clk);
    release dut.r_wrCount;
    doXfer(1'b0, 1'b1, 5'd28, 4'hF, 32'h5A5A_5A5A, rd, lat);
    nChecks++; if (lat != 2) begin nFails++; $display("[TB] FAIL unmapped_ack: got lat %0d expected 2", lat); end
    doXfer(1'b0, 1'b0, 5'd28, 4'hF, 32'h0, rd, lat);
    nChecks++; if (rd !== 32'h0) begin nFails++; $display("[TB] FAIL unmapped_read: got %h expected 0", rd); end
    doXfer(1'b0, 1'b0, 5'd20, 4'hF, 32'h0, rd, lat);
    nChecks++; if (rd !== 32'h0000_FFFF) begin nFails++; $display("[TB] FAIL wrcount_max: got %h expected 0000ffff", rd); end
    doXfer(1'b0, 1'b1, 5'd28, 4'hF, 32'h0, rd, lat);
    doXfer(1'b0, 1'b0, 5'd20, 4'hF, 32'h0, rd, lat);
    nChecks++; if (rd !== 32'h0) begin nFails++; $display("[TB] FAIL wrcount_wrap: got %h expected 0", rd); end
    doXfer(1'b0, 1'b1, 5'd0, 4'hF, 32'h0, rd, lat);
    doXfer(1'b0, 1'b0, 5'd0, 4'hF, 32'h0, rd, lat);
    nChecks++; if (rd !== ID_EXP) begin nFails++; $display("[TB] FAIL id_readonly: got %h expected %h", rd, ID_EXP); end
    doXfer(1'b0, 1'b0, 5'd20, 4'hF, 32'h0, rd, lat);
    nChecks++; if (rd !== 32'h1) begin nFails++; $display("[TB] FAIL wrcount_ro_write: got %h expected 1", rd); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd;
    int lat;
    @(negedge clk);
    driveBus(1'b1, 1'b1, 1'b1, 1'b1, 5'd4, 4'hF, 32'hCAFE_F00D);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    nChecks++; if (bus3.wb_ack_o !== 1'b0) begin nFails++; $display("[TB] FAIL midrst_ack: got %b expected 0", bus3.wb_ack_o); end
    repeat (4) @(negedge clk);
    nChecks++; if (bus3.wb_ack_o !== 1'b0) begin nFails++; $display("[TB] FAIL midrst_hold_ack: got %b expected 0", bus3.wb_ack_o); end
    driveBus(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 4'h0, 32'h0);
    rst_n = 1'b1;
    doXfer(1'b1, 1'b0, 5'd4, 4'hF, 32'h0, rd, lat);
    nChecks++; if (rd !== 32'h0) begin nFails++; $display("[TB] FAIL midrst_scratch0: got %h expected 0", rd); end
    doXfer(1'b0, 1'b0, 5'd4, 4'hF, 32'h0, rd, lat);
    nChecks++; if (rd !== 32'h0) begin nFails++; $display("[TB] FAIL rst_clears_scratch0: got %h expected 0", rd); end

    // Reset while ack is high must drop it without waiting for a clock.
    doXfer(1'b0, 1'b0, 5'd0, 4'hF, 32'h0, rd, lat);
    nChecks++; if (rd !== ID_EXP) begin nFails++; $display("[TB] FAIL pre_async_read: got %h expected %h", rd, ID_EXP); end
    rst_n = 1'b0;
    #1;
    nChecks++; if (bus.wb_ack_o !== 1'b0) begin nFails++; $display("[TB] FAIL async_ack_drop: got %b expected 0", bus.wb_ack_o); end
    nChecks++; if (bus.wb_dat_o !== 32'h0) begin nFails++; $display("[TB] FAIL async_dat_drop: got %h expected 0", bus.wb_dat_o); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    nChecks = 0;
    nFails  = 0;
    $display("[TB] starting wb_reg_responder bench");
    test_reset();
    test_read_all();
    test_byte_lanes();
    test_back_to_back();
    test_abort();
    test_irq();
    test_wrap();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/wb_reg_responder.md
# wb_reg_responder

Wishbone classic-cycle responder (slave) for the UART test environment: it answers the same 5-bit address / 32-bit data Wishbone bus the UART host agents drive, and exposes a small register file with ID, scratch, control, sticky W1C status and write-counter registers. It gives the master-side driver and monitor a known-good target with programmable wait states. It also raises a level interrupt that mirrors the UART `int_o` behaviour.

## Interface
- `WAIT_STATES`, default 1: cycles inserted between request sample and `wb_ack_o`; legal range 0–7.
- `ID_VALUE`, default 32'h5541_5254: value returned by the ID register.
- `wb_clk_i`  in  1  bus clock; all state on rising edge.
- `wb_rst_ni`  in  1  reset, asynchronous assert, active-low, synchronous deassert at source.
- `wb_cyc_i`  in  1  cycle valid.
- `wb_stb_i`  in  1  strobe.
- `wb_we_i`  in  1  1 = write, 0 = read.
- `wb_addr_i`  in  5  byte address; `wb_addr_i[4:2]` selects the word, `[1:0]` ignored.
- `wb_sel_i`  in  4  byte lane enables for writes; `sel[n]` covers `dat[8n+7:8n]`.
- `wb_dat_i`  in  32  write data.
- `wb_dat_o`  out  32  read data, valid only while `wb_ack_o`=1, else 0.
- `wb_ack_o`  out  1  single-cycle acknowledge.
- `event_i`  in  8  event pulses, sampled every cycle.
- `int_o`  out  1  level interrupt.

## Operation
- Register map (word index): 0 ID (RO); 1 SCRATCH0 (RW); 2 SCRATCH1 (RW); 3 CTRL (RW, bit0 `irq_en`, bits[31:1] read 0); 4 STATUS (bits[7:0] sticky, W1C, [31:8] read 0); 5 WR_COUNT (RO, 16-bit, [31:16] read 0); 6–7 unmapped (read 0, writes ignored, still acked).
- FSM states: IDLE, WAIT, ACK.
  - IDLE → ACK when `cyc&stb` and `WAIT_STATES`=0.
  - IDLE → WAIT when `cyc&stb` and `WAIT_STATES`>0; wait counter loads `WAIT_STATES-1`.
  - WAIT → ACK when counter = 0 and `cyc&stb` are still high.
  - WAIT decrements otherwise.
  - WAIT → IDLE (abort) if `cyc` or `stb` drops: no write, no ack.
  - ACK → IDLE unconditionally.
- Address, `we`, `sel` and data are captured on the IDLE sample edge; later changes are ignored.
- A write commits on the edge entering ACK. Only lanes with `sel` set are updated; `sel`=0 still acks and still counts.
- WR_COUNT increments by 1 on every acked write, including unmapped and RO targets. It wraps 0xFFFF → 0x0000.
- STATUS: bit n sets when `event_i[n]`=1. An acked write with `sel[0]` and `dat_i[n]`=1 clears bit n. If set and clear hit the same edge, set wins.
- `int_o` = `irq_en` & |STATUS[7:0], registered.

## Timing
- Reset values: `wb_ack_o`=0, `wb_dat_o`=0, `int_o`=0, FSM=IDLE, SCRATCH0/1=0, CTRL=0, STATUS=0, WR_COUNT=0.
- Latency: `cyc&stb` first sampled at edge k → `wb_ack_o` high during cycle k+`WAIT_STATES`+1, for exactly one cycle.
- Read data is registered together with ack.
- Request held high after ack: the new transaction is sampled in the IDLE cycle following ACK, so acks are never on consecutive cycles.
- `int_o` follows a STATUS/CTRL change by one cycle. A W1C clear drops `int_o` the cycle after ack.
- Reset mid-transaction: immediate return to IDLE, no ack, no commit; `wb_ack_o` drops asynchronously.

## Structure
- Shared package `wb_reg_pkg`:
  - FSM state enum.
  - Word-index constants `REG_ID` … `REG_WR_COUNT`.
  - `ADDR_W`=5, `DATA_W`=32.
- One natural sub-module, `wb_byte_lane_merge`: combinational old/new merge per `sel` lane. Reused by SCRATCH0/1 and CTRL.

## Test plan
- Reset, then read all 8 words, `WAIT_STATES`=1 → ID=32'h5541_5254, all others 0. Ack lands 2 cycles after sample.
- Write SCRATCH0=32'hDEAD_BEEF with `sel`=4'b0101, then read → 32'h00AD_00EF; WR_COUNT=1.
- Drop `stb` after 1 cycle with `WAIT_STATES`=3 → no ack, SCRATCH1 unchanged, WR_COUNT unchanged.
- CTRL=1, pulse `event_i`=8'h04 → `int_o`=1. Write STATUS=0x04 in the same cycle `event_i[2]` pulses again → bit stays set, `int_o`=1. Write 0x04 again → `int_o`=0.
- Preload WR_COUNT to 0xFFFF via 65535 writes to unmapped word 7, then one more write → WR_COUNT reads 0.
- Assert `wb_rst_ni`=0 during WAIT of a SCRATCH0 write → `wb_ack_o`=0 immediately; SCRATCH0 reads 0 after release.
